// File: rtl/conv_tree_ser_scheduler_if.sv
// Handshake and serializer-side bus for conv_tree_ser_scheduler.
// master = scheduler side, slave = requesters/serializer side.
interface conv_tree_ser_scheduler_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WORD_W = 256
) ();
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [WORD_W-1:0]       ser_par;
  logic                    ser_load;
  logic                    ser_en;
  logic                    frame_done;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic [15:0]             frame_cnt;

  modport master (
    input  req_valid, req_data,
    output req_ready, ser_par, ser_load, ser_en, frame_done, grant_id, busy, frame_cnt
  );

  modport slave (
    output req_valid, req_data,
    input  req_ready, ser_par, ser_load, ser_en, frame_done, grant_id, busy, frame_cnt
  );
endinterface

// File: rtl/conv_tree_ser_scheduler.sv
// Round-robin scheduler sharing one serializer among N_REQ word producers.
// Define SER_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module conv_tree_ser_scheduler #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WORD_W     = 256,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic                      CLK,
  input logic                      RESET,
  conv_tree_ser_scheduler_if.master bus
);
  localparam int unsigned ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W    = $clog2(WORD_W);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WORD_W-1:0] ser_par;
  logic              ser_load;
  logic              ser_en;
  logic              frame_done;
  logic [ID_W-1:0]   grant_id;
  logic [15:0]       frame_cnt;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand_idx;
  logic [WORD_W-1:0] win_word;

`ifdef SER_SCHED_FIXED_PRIO_EN
  // Scan from the top so the lowest valid index is the final assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_idx = ID_W'(N_REQ - 1 - k);
      if (bus.req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;

  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // ptr+1+k never exceeds 2*N_REQ-1, so one wrap subtraction suffices.
      cand = {{(32-ID_W){1'b0}}, ptr} + 1 + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = ID_W'(cand);
      if (!win_found && bus.req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end
`endif

  always_comb begin
    win_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) win_word = bus.req_data[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ser_par    <= '0;
      ser_load   <= 1'b0;
      ser_en     <= 1'b0;
      frame_done <= 1'b0;
      grant_id   <= '0;
      frame_cnt  <= '0;
`ifndef SER_SCHED_FIXED_PRIO_EN
      ptr        <= ID_W'(N_REQ - 1);
`endif
    end else begin
      ser_load   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            ser_par  <= win_word;
            grant_id <= win_idx;
`ifndef SER_SCHED_FIXED_PRIO_EN
            ptr      <= win_idx;
`endif
            ser_load <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          bit_cnt <= '0;
          ser_en  <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          // Registered pulse lands on the final enabled cycle.
          if (bit_cnt == CNT_W'(WORD_W - 2)) frame_done <= 1'b1;
          if (bit_cnt == CNT_W'(WORD_W - 1)) begin
            ser_en    <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            gap_cnt   <= '0;
            state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE && win_found) ? (N_REQ'(1) << win_idx) : '0;
  assign bus.ser_par    = ser_par;
  assign bus.ser_load   = ser_load;
  assign bus.ser_en     = ser_en;
  assign bus.frame_done = frame_done;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_cnt  = frame_cnt;
endmodule

// File: doc/conv_tree_ser_scheduler.md
Name: conv_tree_ser_scheduler

Overview:
- Round-robin scheduler that shares one conv_tree_serializer between N_REQ parallel-word producers.
- Accepts one WORD_W-bit word per frame from the winning requester and holds it on the serializer's parallel input.
- Pulses a load strobe, then gates the serializer for exactly WORD_W shift cycles, followed by a fixed inter-frame gap.
- Sits between the convolution-tree output buffers and the serializer.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_W, 256, parallel word width; equals the serializer PAR_IN width (8 x 32).
- GAP_CYCLES, 2, idle cycles after each frame before the next accept (0 allowed).

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ_VALID  in  N_REQ  requester i has a word pending.
- REQ_DATA  in  N_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W].
- REQ_READY  out  N_REQ  one-hot; a handshake completes when REQ_VALID[i] and REQ_READY[i] are both high in the same cycle.
- SER_PAR  out  WORD_W  registered word driven to serializer PAR_IN.
- SER_LOAD  out  1  one-cycle load strobe to the serializer.
- SER_EN  out  1  serializer shift enable, high for exactly WORD_W cycles per frame.
- FRAME_DONE  out  1  one-cycle pulse on the last SER_EN cycle.
- GRANT_ID  out  $clog2(N_REQ)  index of the last accepted requester.
- BUSY  out  1  high in every state except IDLE.
- FRAME_CNT  out  16  count of completed frames; wraps at 65535 -> 0.

Behaviour:
- Reset (RESET low, asynchronous):
  - State = IDLE.
  - REQ_READY, SER_LOAD, SER_EN, FRAME_DONE, BUSY = 0.
  - SER_PAR = 0, GRANT_ID = 0, FRAME_CNT = 0.
  - RR pointer = N_REQ-1, so requester 0 has highest priority first.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - REQ_READY is combinational: one-hot on the first requester with REQ_VALID set, searching from pointer+1 modulo N_REQ. It is 0 if no REQ_VALID is set.
  - On a handshake edge: SER_PAR <= winner's word, GRANT_ID <= winner, pointer <= winner, state -> LOAD.
- LOAD:
  - SER_LOAD = 1 for one cycle; REQ_READY = 0; state -> SHIFT.
  - Bit counter cleared to 0.
- SHIFT:
  - SER_EN = 1; bit counter increments each cycle.
  - At count == WORD_W-1: FRAME_DONE = 1, FRAME_CNT += 1, state -> GAP. If GAP_CYCLES == 0, state -> IDLE instead.
- GAP:
  - Counts GAP_CYCLES cycles with all strobes low, then state -> IDLE.
- Latency:
  - Handshake at cycle t; SER_LOAD at t+1; SER_EN at t+2 .. t+1+WORD_W.
  - Earliest next handshake at t+2+WORD_W+GAP_CYCLES.
- SER_PAR holds its value from capture until the next capture. Changes on REQ_DATA after acceptance are ignored.
- A requester may drop REQ_VALID at any time before its handshake. This has no side effect, and the pointer does not advance.
- REQ_VALID asserted outside IDLE: no REQ_READY; the request waits.
- Single persistent requester: served back-to-back at the minimum frame period.
- All requesters valid continuously: grant order 0,1,2,...,N_REQ-1,0.
- Reset asserted mid-SHIFT or mid-GAP:
  - In-flight frame dropped; FRAME_DONE not pulsed; FRAME_CNT cleared.
  - After release, arbitration restarts from requester 0.
- GRANT_ID and pointer wrap from N_REQ-1 to 0.

Optional Feature:
- Macro: SER_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins every arbitration; the pointer is unused. Requester 0 held valid starves all others (intended for a latency-critical lane).
- Not defined: round-robin as specified above.

Test Plan:
1. Reset release, no REQ_VALID for 20 cycles -> all outputs 0, BUSY 0, FRAME_CNT 0.
2. REQ_VALID=4'b0100, REQ_DATA[2] = {32'hFFFFFFFF, 32'h3FFFFFFF, 32'h8FFFFFFF, 32'h1FFFFFFF, 32'd23456, 32'd12356, 32'd12456, 32'd1}, handshake at t -> REQ_READY=4'b0100 at t; SER_LOAD at t+1; SER_PAR equals the word; SER_EN high t+2..t+257; FRAME_DONE at t+257; FRAME_CNT=1; IDLE at t+260.
3. REQ_VALID=4'b1111 held for 8 frames -> GRANT_ID sequence 0,1,2,3,0,1,2,3; handshakes exactly 260 cycles apart.
4. Handshake at t, REQ_DATA changed to 2,3,4,5 at t+5 -> SER_PAR unchanged until the next handshake.
5. RESET low at t+100 of a frame, released at t+103 -> no FRAME_DONE; FRAME_CNT=0; with REQ_VALID=4'b1010 the first grant is requester 1.
6. SER_SCHED_FIXED_PRIO_EN defined, REQ_VALID=4'b1111 held for 4 frames -> GRANT_ID 0,0,0,0; REQ_READY[3:1] never asserted.
